// File: rtl/shift_right_halfword_seq.sv
// Sequential per-halfword logical shift right: each of the eight 16-bit lanes is
// shifted by a count derived from the negated low bits of its RB lane, SHIFT_PER_CYCLE bits per cycle.
module shift_right_halfword_seq #(
    parameter int unsigned SHIFT_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] register_RA,
    input  logic [127:0] register_RB,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         abort,
    output logic [127:0] register_RT,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [4:0] Step = 5'(SHIFT_PER_CYCLE);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0][15:0]  work_q, work_d;
    logic [7:0][4:0]   rem_q, rem_d;
    logic              ready_q;
    logic              all_zero;

    // Shift amount (0 - rb) mod 32, clamped to 16 since larger counts clear the lane anyway.
    function automatic logic [4:0] clamp_cnt(input logic [15:0] rb);
        logic [4:0] cnt;
        cnt = 5'd0 - rb[4:0];
        return (cnt > 5'd16) ? 5'd16 : cnt;
    endfunction

    function automatic logic [4:0] step_amt(input logic [4:0] rem);
        return (rem < Step) ? rem : Step;
    endfunction

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        all_zero = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (in_valid && ready_q) begin
                    for (int j = 0; j < 8; j++) begin
                        work_d[j] = register_RA[j*16 +: 16];
                        rem_d[j]  = clamp_cnt(register_RB[j*16 +: 16]);
                        if (rem_d[j] != 5'd0) all_zero = 1'b0;
                    end
                    state_d = all_zero ? StDone : StShift;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                    work_d  = '0;
                    rem_d   = '0;
                end else begin
                    for (int j = 0; j < 8; j++) begin
                        if (rem_q[j] != 5'd0) begin
                            work_d[j] = work_q[j] >> step_amt(rem_q[j]);
                            rem_d[j]  = rem_q[j] - step_amt(rem_q[j]);
                        end
                        if (rem_d[j] != 5'd0) all_zero = 1'b0;
                    end
                    if (all_zero) state_d = StDone;
                end
            end
            StDone: begin
                if (abort) begin
                    state_d = StIdle;
                    work_d  = '0;
                    rem_d   = '0;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                work_d  = '0;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            ready_q <= 1'b1;
        end
    end

    // ready_q keeps in_ready low until the first edge after reset release.
    assign in_ready    = (state_q == StIdle) && ready_q;
    assign out_valid   = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign register_RT = out_valid ? work_q : '0;

endmodule

// File: doc/shift_right_halfword_seq.md
SHIFT_RIGHT_HALFWORD_SEQ -- requirements
Module: shift_right_halfword_seq

Interface
REQ-001 SHALL have parameter SHIFT_PER_CYCLE, default 1, the number of bit positions each lane shifts per SHIFT cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port register_RA, input, 128 bits: source operand; halfword lane j (j=0..7) is register_RA[j*16 +: 16].
REQ-005 SHALL have port register_RB, input, 128 bits: per-lane shift-control operand, with the same lane mapping.
REQ-006 SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-008 SHALL have port abort, input, 1 bit: synchronous discard of the operation in flight.
REQ-009 SHALL have port register_RT, output, 128 bits: result, with the same lane mapping.
REQ-010 SHALL have port out_valid, output, 1 bit: register_RT holds a completed result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL implement logical shift right halfword, immediate-free form: per lane, cnt = (0 - RB_lane) & 0x1F; RT_lane = RA_lane >> cnt with zero fill; RT_lane = 0 when cnt >= 16.
REQ-014 SHALL use a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; an operation is accepted on a rising edge with in_valid && in_ready.
REQ-016 SHALL, on accept, load each lane's RA into a 16-bit working register and load a 5-bit remaining count of min(cnt, 16).
REQ-017 SHALL, on accept, go directly to DONE if all eight remaining counts are 0; otherwise go to SHIFT.
REQ-018 SHALL, on each SHIFT cycle and per lane with remaining > 0: shift the working register right by min(remaining, SHIFT_PER_CYCLE) with zero fill, and subtract that amount from remaining; lanes with remaining = 0 hold.
REQ-019 SHALL leave SHIFT for DONE on the edge whose step brings every remaining count to 0.
REQ-020 SHALL therefore give a latency from accept edge to out_valid high of max(1, ceil(maxcnt/SHIFT_PER_CYCLE)) cycles, where maxcnt is the largest clamped lane count; the maximum is 16 cycles when SHIFT_PER_CYCLE = 1.
REQ-021 SHALL drive out_valid = 1 only in DONE, with register_RT equal to the working registers and stable until handshake.
REQ-022 SHALL leave DONE for IDLE on the edge with out_ready = 1; out_valid and register_RT hold while out_ready = 0, for any number of cycles.
REQ-023 SHALL NOT accept a new operation in SHIFT or DONE; in_valid is ignored there.
REQ-024 SHALL, when abort = 1 on an edge in SHIFT or DONE, go to IDLE, clear register_RT to 0 and drop out_valid, with no result delivered.
REQ-025 SHALL give abort priority over out_ready and over completion of the final SHIFT step.
REQ-026 SHALL ignore abort in IDLE, including an abort coinciding with accept; the accept proceeds.
REQ-027 SHALL drive register_RT = 0 in IDLE and SHIFT; intermediate values are never visible.
REQ-028 SHALL latch operands only at accept; later changes to register_RA and register_RB have no effect.

Reset
REQ-029 SHALL, while reset_n = 0, immediately force state IDLE, register_RT = 0, out_valid = 0, busy = 0, in_ready = 0, and all working registers and counts = 0.
REQ-030 SHALL drive in_ready = 1 from the first rising edge after reset_n deasserts.
REQ-031 SHALL abandon an in-flight operation on reset mid-operation, with no result delivered afterwards.

Verification
REQ-032 SHALL pass: all RA lanes 16'h8001, RB lanes 16'hFFFF (cnt 1), SHIFT_PER_CYCLE = 1 -> out_valid one cycle after accept, all RT lanes 16'h4000.
REQ-033 SHALL pass: RB = 0 (cnt 0), RA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> out_valid one cycle after accept, RT = RA.
REQ-034 SHALL pass: lane RB values 16'hFFF0 (cnt 16), 16'h0001 (cnt 31), 16'hFFFC (cnt 4), RA lanes 16'hFFFF -> RT lanes 0, 0, 16'h0FFF; latency 16 at SHIFT_PER_CYCLE = 1 and 4 at SHIFT_PER_CYCLE = 4.
REQ-035 SHALL pass: result reached with out_ready low for 5 cycles -> out_valid and RT stable throughout, in_ready = 0, then IDLE one edge after out_ready = 1.
REQ-036 SHALL pass: abort pulsed on cycle 3 of a 16-cycle operation -> IDLE next edge, no out_valid; a following operation completes correctly.
REQ-037 SHALL pass: reset_n pulsed low mid-SHIFT -> outputs zero asynchronously, in_ready = 1 after release, no stale result.
